// File: rtl/rapid_fetch_queue.sv
// Instruction-fetch front end: issues one word fetch at a time to the instruction cache and
// buffers PC-tagged responses in a small FIFO that feeds decode over valid/ready.
module rapid_fetch_queue #(
    parameter int unsigned XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned WORD_WIDTH   = 4,
    parameter int unsigned QUEUE_DEPTH  = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    output logic                               imem_req_valid,
    input  logic                               imem_req_ready,
    output logic [XLEN-1:0]                    imem_req_addr,
    input  logic                               imem_resp_valid,
    input  logic [31:0]                        imem_resp_data,
    input  logic                               redirect_valid,
    input  logic [XLEN-1:0]                    redirect_pc,
    input  logic                               halt_req,
    input  logic                               resume,
    output logic                               inst_valid,
    input  logic                               inst_ready,
    output logic [31:0]                        inst_data,
    output logic [XLEN-1:0]                    inst_pc,
    output logic                               halted,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count
);

    localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CntW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(QUEUE_DEPTH);
    localparam logic [XLEN-1:0] AlignMask = ~(XLEN'(WORD_WIDTH - 1));
    localparam logic [XLEN-1:0] PcStep = XLEN'(WORD_WIDTH);

    typedef enum logic [1:0] {StFetch, StWait, StNext, StHalt} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              drop_q, drop_d;

    logic [31:0]       data_mem [QUEUE_DEPTH];
    logic [XLEN-1:0]   pc_mem   [QUEUE_DEPTH];
    logic [PtrW-1:0]   wr_q, rd_q;
    logic [CntW-1:0]   count_q;

    logic req_fire;
    logic push;
    logic pop;

    // Outputs are held low while reset is asserted, even though the state already reads FETCH.
    assign imem_req_valid = !rst && (state_q == StFetch) && !halt_req && (count_q < CntFull);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign inst_valid  = (count_q != '0);
    assign inst_data   = data_mem[rd_q];
    assign inst_pc     = pc_mem[rd_q];
    assign halted      = (state_q == StHalt);
    assign queue_count = count_q;

    assign push = (state_q == StWait) && imem_resp_valid && !drop_q && !redirect_valid;
    assign pop  = inst_valid && inst_ready && !redirect_valid;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        unique case (state_q)
            StFetch: begin
                if (halt_req) begin
                    state_d = StHalt;
                end else if (req_fire) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (imem_resp_valid) begin
                    drop_d  = 1'b0;
                    state_d = drop_q ? StFetch : StNext;
                end
            end
            StNext: begin
                pc_d    = pc_q + PcStep;
                state_d = halt_req ? StHalt : StFetch;
            end
            StHalt: begin
                if (resume) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase

        if (redirect_valid) begin
            pc_d = redirect_pc & AlignMask;
            case (state_q)
                StFetch: if (req_fire) drop_d = 1'b1;
                StWait: begin
                    // A response arriving with the redirect is already stale; nothing left to drop.
                    if (imem_resp_valid) begin
                        drop_d  = 1'b0;
                        state_d = StFetch;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
                StNext:  state_d = StFetch;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= RESET_VECTOR;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (redirect_valid) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                data_mem[wr_q] <= imem_resp_data;
                pc_mem[wr_q]   <= pc_q;
                wr_q           <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rapid_fetch_queue.sv
// Directed bench for rapid_fetch_queue: a cache model with programmable latency feeds a
// scoreboard of expected {pc, data} entries that a monitor checks against decode-side pops.
module tb_rapid_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        resume;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        halted;
    logic [2:0]  queue_count;

    always #5 clk = ~clk;

    rapid_fetch_queue dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .halt_req        (halt_req),
        .resume          (resume),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .halted          (halted),
        .queue_count     (queue_count)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    int          total = 0;
    int          bad = 0;
    ent_t        sb[$];
    ent_t        mon_e;
    ent_t        push_e;
    logic [31:0] exp_addr = '0;
    int unsigned lat = 0;
    int          pops = 0;
    logic [31:0] last_pc = '0;

    logic        cache_resp = 1'b0;
    logic [31:0] cache_data = '0;
    logic        man_resp = 1'b0;
    logic [31:0] man_data = '0;
    logic        busy = 1'b0;
    logic [31:0] paddr = '0;
    int unsigned cnt = 0;

    assign imem_resp_valid = cache_resp | man_resp;
    assign imem_resp_data  = man_resp ? man_data : cache_data;

    function automatic logic [31:0] mkdata(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h1300_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Cache model: accepts a request, answers after `lat` extra cycles, forgets it on reset.
    always @(negedge clk) begin
        if (rst) begin
            busy       = 1'b0;
            cache_resp = 1'b0;
        end else begin
            cache_resp = 1'b0;
            if (busy) begin
                if (cnt == 0) begin
                    cache_resp = 1'b1;
                    cache_data = mkdata(paddr);
                    busy       = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr_seq", imem_req_addr, exp_addr);
                exp_addr    = exp_addr + 32'd4;
                push_e.pc   = imem_req_addr;
                push_e.data = mkdata(imem_req_addr);
                sb.push_back(push_e);
                busy  = 1'b1;
                paddr = imem_req_addr;
                cnt   = lat;
            end
        end
    end

    // Decode-side monitor; a pop offered during a redirect is cancelled by the flush.
    always @(negedge clk) begin
        if (!rst && inst_valid && inst_ready && !redirect_valid) begin
            chk("pop_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("pop_pc", inst_pc, mon_e.pc);
                chk("pop_data", inst_data, mon_e.data);
            end
            pops++;
            last_pc = inst_pc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pops(input int n, input string tag);
        int   start;
        logic seen;
        start = pops;
        seen  = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            #1;
            if (pops - start >= n) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_count(input logic [2:0] n, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (queue_count == n) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_req(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt_req       = 1'b0;
        resume         = 1'b0;
        inst_ready     = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_count", 32'(queue_count), 32'd0);
        chk("rst_inst_data", inst_data, 32'd0);

        // 1: streaming fetch with a zero-latency cache
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t1_first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t1_first_req_addr", imem_req_addr, 32'd0);
        wait_pops(4, "t1_four_pops");
        chk("t1_last_pc", last_pc, 32'd12);

        // 2: decode stalled, FIFO fills and fetching stops
        step();
        inst_ready = 1'b0;
        wait_count(3'd4, "t2_fill");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_no_req", 32'(imem_req_valid), 32'd0);
            chk("t2_count", 32'(queue_count), 32'd4);
        end

        // 5: halt with a full FIFO, drain while halted, then resume at the held pc
        step();
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        @(negedge clk);
        chk("t5_halted", 32'(halted), 32'd1);
        step();
        inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t5_halt_hold", 32'(halted), 32'd1);
            chk("t5_halt_no_req", 32'(imem_req_valid), 32'd0);
        end
        chk("t5_drained_count", 32'(queue_count), 32'd0);
        chk("t5_drained_valid", 32'(inst_valid), 32'd0);
        step();
        resume = 1'b1;
        step();
        resume = 1'b0;
        @(negedge clk);
        chk("t5_resumed", 32'(halted), 32'd0);
        chk("t5_resume_req", 32'(imem_req_valid), 32'd1);
        chk("t5_resume_addr", imem_req_addr, exp_addr);

        // 3: redirect while a slow response is outstanding
        step();
        lat = 3;
        wait_req("t3_slow_req");
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        sb.delete();
        exp_addr = 32'h100;
        lat      = 0;
        @(negedge clk);
        chk("t3_flush_count", 32'(queue_count), 32'd0);
        chk("t3_flush_valid", 32'(inst_valid), 32'd0);
        chk("t3_wait_no_req", 32'(imem_req_valid), 32'd0);
        wait_req("t3_new_req");
        chk("t3_new_addr", imem_req_addr, 32'h100);
        wait_pops(1, "t3_pop");
        chk("t3_first_pc", last_pc, 32'h100);

        // 4: redirect coincident with a pop on a full FIFO
        step();
        inst_ready = 1'b0;
        wait_count(3'd4, "t4_fill");
        step();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        @(negedge clk);
        chk("t4_pop_offered", 32'(inst_valid), 32'd1);
        step();
        redirect_valid = 1'b0;
        sb.delete();
        exp_addr = 32'h200;
        @(negedge clk);
        chk("t4_count", 32'(queue_count), 32'd0);
        chk("t4_valid", 32'(inst_valid), 32'd0);
        chk("t4_req_addr", imem_req_addr, 32'h200);
        wait_pops(1, "t4_pop");
        chk("t4_first_pc", last_pc, 32'h200);

        // 6: reset during WAIT, then a late response
        step();
        lat = 5;
        wait_req("t6_slow_req");
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t6_rst_addr", imem_req_addr, 32'd0);
        chk("t6_rst_count", 32'(queue_count), 32'd0);
        step();
        rst = 1'b0;
        sb.delete();
        exp_addr = '0;
        lat      = 0;
        man_resp = 1'b1;
        man_data = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t6_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t6_req_addr", imem_req_addr, 32'd0);
        step();
        man_resp = 1'b0;
        @(negedge clk);
        chk("t6_late_no_push", 32'(queue_count), 32'd0);
        chk("t6_late_no_valid", 32'(inst_valid), 32'd0);
        wait_pops(1, "t6_pop");
        chk("t6_first_pc", last_pc, 32'd0);

        step();
        imem_req_ready = 1'b0;
        repeat (10) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
